// File: rtl/xframepad_rt.sv
// Runtime-configurable frame padder: emits exactly iv_frame_len samples per frame,
// real data up to iv_max_data, then pad. Optional status counters: XFRAMEPAD_STATUS_EN.
module xframepad_rt #(
  parameter int              BWID         = 16,
  parameter int              LEN_W        = 11,
  parameter logic [BWID-1:0] PAD_VALUE    = '0,
  parameter bit              PAD_FREE_RUN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BWID-1:0]  iv_data,
  input  logic             i_nd,
  input  logic             i_head,
  input  logic             i_tail,
  input  logic [LEN_W-1:0] iv_frame_len,
  input  logic [LEN_W-1:0] iv_max_data,
  input  logic             i_pad_mode,
  output logic [BWID-1:0]  ov_data,
  output logic             o_dv,
  output logic             o_head,
  output logic             o_tail,
`ifdef XFRAMEPAD_STATUS_EN
  output logic [31:0]      ov_frame_cnt,
  output logic [15:0]      ov_trunc_cnt,
`endif
  output logic             o_err
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAD} state_t;

  state_t           r_state;
  logic [LEN_W-1:0] r_n, r_len, r_max;
  logic             r_mode;
  logic [BWID-1:0]  r_hold, r_data;
  logic             r_dv, r_head, r_tail, r_err;

  state_t           w_state_nxt;
  logic [LEN_W-1:0] w_n_nxt, w_len_cur, w_max_cur, w_max_in;
  logic [BWID-1:0]  w_emit_data;
  logic             w_emit, w_is_real, w_load, w_head, w_tail, w_err;

  assign w_max_in = (iv_max_data < iv_frame_len) ? iv_max_data : iv_frame_len;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    w_state_nxt = r_state;
    w_n_nxt     = r_n;
    w_len_cur   = r_len;
    w_max_cur   = r_max;
    w_emit_data = r_data;
    w_emit      = 1'b0;
    w_is_real   = 1'b0;
    w_load      = 1'b0;
    w_head      = 1'b0;
    w_tail      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_nd && i_head) begin
          if (iv_frame_len == '0) begin
            w_err = 1'b1;
          end else begin
            w_load      = 1'b1;
            w_emit      = 1'b1;
            w_is_real   = 1'b1;
            w_head      = 1'b1;
            w_emit_data = iv_data;
            w_n_nxt     = LEN_W'(1);
            w_len_cur   = iv_frame_len;
            w_max_cur   = w_max_in;
          end
        end
      end
      S_DATA: begin
        w_err = i_nd & i_head;
        if (i_nd) begin
          w_emit      = 1'b1;
          w_is_real   = 1'b1;
          w_emit_data = iv_data;
          w_n_nxt     = r_n + LEN_W'(1);
        end
      end
      S_PAD: begin
        w_err = i_nd & i_head;
        if (PAD_FREE_RUN || i_nd) begin
          w_emit      = 1'b1;
          w_emit_data = r_mode ? r_hold : PAD_VALUE;
          w_n_nxt     = r_n + LEN_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // '>=' rather than '==' so that max 0 still drops to PAD after the head sample.
    if (w_emit) begin
      if (w_n_nxt == w_len_cur) begin
        w_tail      = 1'b1;
        w_state_nxt = S_IDLE;
      end else if (w_is_real && (i_tail || w_n_nxt >= w_max_cur)) begin
        w_state_nxt = S_PAD;
      end else if (r_state == S_IDLE) begin
        w_state_nxt = S_DATA;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_n     <= '0;
      r_len   <= '0;
      r_max   <= '0;
      r_mode  <= 1'b0;
      r_hold  <= '0;
      r_data  <= '0;
      r_dv    <= 1'b0;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_n     <= w_n_nxt;
      r_dv    <= w_emit;
      r_head  <= w_head;
      r_tail  <= w_tail;
      r_err   <= w_err;
      if (w_emit) r_data <= w_emit_data;
      if (w_emit && w_is_real) r_hold <= iv_data;
      if (w_load) begin
        r_len  <= iv_frame_len;
        r_max  <= w_max_in;
        r_mode <= i_pad_mode;
      end
    end
  end

  assign ov_data = r_data;
  assign o_dv    = r_dv;
  assign o_head  = r_head;
  assign o_tail  = r_tail;
  assign o_err   = r_err;

`ifdef XFRAMEPAD_STATUS_EN
  logic [31:0] r_frame_cnt;
  logic [15:0] r_trunc_cnt;
  logic        w_trunc;

  // Truncated: the move to PAD was forced by the max limit, not by the input tail.
  assign w_trunc = w_emit & w_is_real & ~i_tail & (w_state_nxt == S_PAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
      r_trunc_cnt <= '0;
    end else begin
      if (w_tail && (r_frame_cnt != '1)) r_frame_cnt <= r_frame_cnt + 32'd1;
      if (w_trunc && (r_trunc_cnt != '1)) r_trunc_cnt <= r_trunc_cnt + 16'd1;
    end
  end

  assign ov_frame_cnt = r_frame_cnt;
  assign ov_trunc_cnt = r_trunc_cnt;
`else
  // Status counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_xframepad_rt.sv
// Self-checking bench for xframepad_rt: two instances (per-i_nd and free-running pad pacing)
// share stimulus and are compared every cycle against a frame-level reference model.
module tb_xframepad_rt;

  localparam int BWID  = 16;
  localparam int LEN_W = 11;
  localparam logic [BWID-1:0] PAD_V = 16'h0000;
`ifdef XFRAMEPAD_STATUS_EN
  localparam int OW = 4 + BWID + 48;
`else
  localparam int OW = 4 + BWID;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [BWID-1:0]  iv_data = '0;
  logic             i_nd = 1'b0, i_head = 1'b0, i_tail = 1'b0, i_pad_mode = 1'b0;
  logic [LEN_W-1:0] iv_frame_len = '0, iv_max_data = '0;

  logic [BWID-1:0]  d0_data, d1_data;
  logic             d0_dv, d0_head, d0_tail, d0_err;
  logic             d1_dv, d1_head, d1_tail, d1_err;
  logic [OW-1:0]    w_obs0, w_obs1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

`ifdef XFRAMEPAD_STATUS_EN
  logic [31:0] d0_fc, d1_fc;
  logic [15:0] d0_tc, d1_tc;
  assign w_obs0 = {d0_fc, d0_tc, d0_dv, d0_head, d0_tail, d0_err, d0_data};
  assign w_obs1 = {d1_fc, d1_tc, d1_dv, d1_head, d1_tail, d1_err, d1_data};
`else
  assign w_obs0 = {d0_dv, d0_head, d0_tail, d0_err, d0_data};
  assign w_obs1 = {d1_dv, d1_head, d1_tail, d1_err, d1_data};
`endif

  xframepad_rt #(.BWID(BWID), .LEN_W(LEN_W), .PAD_VALUE(PAD_V), .PAD_FREE_RUN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .iv_data(iv_data), .i_nd(i_nd), .i_head(i_head), .i_tail(i_tail),
    .iv_frame_len(iv_frame_len), .iv_max_data(iv_max_data), .i_pad_mode(i_pad_mode),
    .ov_data(d0_data), .o_dv(d0_dv), .o_head(d0_head), .o_tail(d0_tail),
`ifdef XFRAMEPAD_STATUS_EN
    .ov_frame_cnt(d0_fc), .ov_trunc_cnt(d0_tc),
`endif
    .o_err(d0_err));

  xframepad_rt #(.BWID(BWID), .LEN_W(LEN_W), .PAD_VALUE(PAD_V), .PAD_FREE_RUN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .iv_data(iv_data), .i_nd(i_nd), .i_head(i_head), .i_tail(i_tail),
    .iv_frame_len(iv_frame_len), .iv_max_data(iv_max_data), .i_pad_mode(i_pad_mode),
    .ov_data(d1_data), .o_dv(d1_dv), .o_head(d1_head), .o_tail(d1_tail),
`ifdef XFRAMEPAD_STATUS_EN
    .ov_frame_cnt(d1_fc), .ov_trunc_cnt(d1_tc),
`endif
    .o_err(d1_err));

  // Frame-level reference: in-frame flag, real/pad phase and emitted-sample count.
  typedef struct {
    bit             active;
    bit             padding;
    int             cnt;
    int             len;
    int             mx;
    bit             mode;
    logic [BWID-1:0] hold;
    logic [BWID-1:0] data;
    bit             dv, head, tail, err;
    longint         frames;
    int             truncs;
  } model_t;

  model_t m0, m1;

  function automatic model_t step(model_t s, bit free_run, bit r, bit nd, bit hd, bit tl,
                                  logic [BWID-1:0] d, int flen, int fmax, bit md);
    model_t n = s;
    bit emit = 1'b0;
    bit real_s = 1'b0;
    n.dv = 0; n.head = 0; n.tail = 0; n.err = 0;
    if (r) begin
      n.active = 0; n.padding = 0; n.cnt = 0; n.len = 0; n.mx = 0; n.mode = 0;
      n.hold = '0; n.data = '0; n.frames = 0; n.truncs = 0;
      return n;
    end
    if (!s.active) begin
      if (nd && hd) begin
        if (flen == 0) n.err = 1;
        else begin
          n.active = 1; n.padding = 0; n.cnt = 0; n.len = flen;
          n.mx = (fmax < flen) ? fmax : flen; n.mode = md;
          n.head = 1; emit = 1; real_s = 1;
        end
      end
    end else if (!s.padding) begin
      n.err = nd && hd;
      if (nd) begin emit = 1; real_s = 1; end
    end else begin
      n.err = nd && hd;
      if (free_run || nd) emit = 1;
    end
    if (emit) begin
      n.cnt = n.cnt + 1;
      n.dv  = 1;
      if (real_s) begin n.data = d; n.hold = d; end
      else n.data = n.mode ? n.hold : PAD_V;
      if (n.cnt == n.len) begin
        n.tail = 1; n.active = 0;
        if (n.frames < 64'hFFFF_FFFF) n.frames = n.frames + 1;
      end else if (real_s && (tl || n.cnt >= n.mx)) begin
        n.padding = 1;
        if (!tl && n.truncs < 65535) n.truncs = n.truncs + 1;
      end
    end
    return n;
  endfunction

  function automatic logic [OW-1:0] expv(model_t m);
    logic [31:0] fc;
    logic [15:0] tc;
    fc = m.frames[31:0];
    tc = m.truncs[15:0];
`ifdef XFRAMEPAD_STATUS_EN
    return {fc, tc, m.dv, m.head, m.tail, m.err, m.data};
`else
    if (fc == 32'hFFFF_FFFF && tc == 16'hFFFF) return '0;
    return {m.dv, m.head, m.tail, m.err, m.data};
`endif
  endfunction

  // Drive one cycle of inputs, clock it, advance both models, settle past the edge.
  task automatic apply(input bit r, input bit nd, input bit hd, input bit tl,
                       input logic [BWID-1:0] d, input int len, input int mx, input bit md);
    rst = r; i_nd = nd; i_head = hd; i_tail = tl; iv_data = d;
    iv_frame_len = LEN_W'(len); iv_max_data = LEN_W'(mx); i_pad_mode = md;
    @(posedge clk);
    m0 = step(m0, 1'b0, r, nd, hd, tl, d, len, mx, md);
    m1 = step(m1, 1'b1, r, nd, hd, tl, d, len, mx, md);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      apply(1'b1, 1'b1, 1'b1, 1'b0, 16'h1234, 4, 4, 1'b0);
      n_checks++;
      if ({w_obs0, w_obs1} !== '0) begin
        n_fail++;
        $display("FAIL reset cyc=%0d got=%h/%h want=0", c, w_obs0, w_obs1);
      end
    end
  endtask

  task automatic test_truncate();
    logic [BWID-1:0] q[$];
    logic [BWID-1:0] want [8];
    int tail_at = -1;
    want = '{16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'h0, 16'h0, 16'h0, 16'h0};
    for (int c = 0; c < 12; c++) begin
      apply(1'b0, c < 8, c == 0, c == 5, 16'hA001 + 16'(c), 8, 4, 1'b0);
      n_checks++;
      if ({w_obs0, w_obs1} !== {expv(m0), expv(m1)}) begin
        n_fail++;
        $display("FAIL truncate cyc=%0d got=%h/%h want=%h/%h", c, w_obs0, w_obs1, expv(m0), expv(m1));
      end
      if (d0_dv) q.push_back(d0_data);
      if (d0_tail) tail_at = c;
    end
    n_checks++;
    if (q.size() != 8 || tail_at != 7) begin
      n_fail++;
      $display("FAIL truncate_len got=%0d tail@%0d want=8 tail@7", q.size(), tail_at);
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (q[i] !== want[i]) begin
          n_fail++;
          $display("FAIL truncate_seq idx=%0d got=%h want=%h", i, q[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_hold_pad();
    logic [BWID-1:0] q[$];
    logic [BWID-1:0] want [6];
    want = '{16'hB001, 16'hB002, 16'hB003, 16'hB003, 16'hB003, 16'hB003};
    for (int c = 0; c < 9; c++) begin
      apply(1'b0, c < 6, c == 0, c == 2, 16'hB001 + 16'(c), 6, 6, 1'b1);
      n_checks++;
      if ({w_obs0, w_obs1} !== {expv(m0), expv(m1)}) begin
        n_fail++;
        $display("FAIL hold_pad cyc=%0d got=%h/%h want=%h/%h", c, w_obs0, w_obs1, expv(m0), expv(m1));
      end
      if (d0_dv) q.push_back(d0_data);
    end
    n_checks++;
    if (q.size() != 6) begin
      n_fail++;
      $display("FAIL hold_pad_len got=%0d want=6", q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (q[i] !== want[i]) begin
          n_fail++;
          $display("FAIL hold_pad_seq idx=%0d got=%h want=%h", i, q[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_pacing();
    int q0[$];
    int q1[$];
    int want0 [5];
    int want1 [5];
    want0 = '{0, 3, 6, 9, 12};
    want1 = '{0, 3, 4, 5, 6};
    for (int c = 0; c < 18; c++) begin
      apply(1'b0, (c % 3) == 0, c == 0, c == 3, 16'hC000 + 16'(c), 5, 5, 1'b0);
      n_checks++;
      if ({w_obs0, w_obs1} !== {expv(m0), expv(m1)}) begin
        n_fail++;
        $display("FAIL pacing cyc=%0d got=%h/%h want=%h/%h", c, w_obs0, w_obs1, expv(m0), expv(m1));
      end
      if (d0_dv) q0.push_back(c);
      if (d1_dv) q1.push_back(c);
    end
    n_checks++;
    if (q0.size() != 5 || q1.size() != 5) begin
      n_fail++;
      $display("FAIL pacing_count got=%0d/%0d want=5/5", q0.size(), q1.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (q0[i] != want0[i] || q1[i] != want1[i]) begin
          n_fail++;
          $display("FAIL pacing_slot idx=%0d got=%0d/%0d want=%0d/%0d", i, q0[i], q1[i], want0[i], want1[i]);
        end
      end
    end
  endtask

  task automatic test_mid_head();
    int dvs = 0, errs = 0, heads = 0;
    for (int c = 0; c < 10; c++) begin
      apply(1'b0, c < 8, c == 0 || c == 2, 1'b0, 16'hD000 + 16'(c), 8, 8, 1'b0);
      n_checks++;
      if ({w_obs0, w_obs1} !== {expv(m0), expv(m1)}) begin
        n_fail++;
        $display("FAIL mid_head cyc=%0d got=%h/%h want=%h/%h", c, w_obs0, w_obs1, expv(m0), expv(m1));
      end
      dvs += int'(d0_dv); errs += int'(d0_err); heads += int'(d0_head);
    end
    n_checks++;
    if (dvs != 8 || errs != 1 || heads != 1) begin
      n_fail++;
      $display("FAIL mid_head_sum got dv=%0d err=%0d head=%0d want 8/1/1", dvs, errs, heads);
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 11; c++) begin
      apply(c == 5, c != 6, c == 0 || c == 7, 1'b0, 16'hE000 + 16'(c),
            (c < 7) ? 8 : 3, (c < 7) ? 2 : 3, 1'b1);
      n_checks++;
      if ({w_obs0, w_obs1} !== {expv(m0), expv(m1)}) begin
        n_fail++;
        $display("FAIL reset_mid cyc=%0d got=%h/%h want=%h/%h", c, w_obs0, w_obs1, expv(m0), expv(m1));
      end
      if (c == 5) begin
        n_checks++;
        if ({w_obs0, w_obs1} !== '0) begin
          n_fail++;
          $display("FAIL reset_mid_zero got=%h/%h want=0", w_obs0, w_obs1);
        end
      end
    end
  endtask

  task automatic test_len_edge();
    // len 1, len 0, max 0 with hold pad and a head on the tail cycle, max 1.
    bit nd_t [12] = '{1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    bit hd_t [12] = '{1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0};
    int ln_t [12] = '{1, 0, 0, 3, 3, 3, 3, 4, 4, 4, 4, 4};
    int mx_t [12] = '{9, 5, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    for (int c = 0; c < 12; c++) begin
      apply(1'b0, nd_t[c], hd_t[c], 1'b0, 16'hF000 + 16'(c), ln_t[c], mx_t[c], c < 7);
      n_checks++;
      if ({w_obs0, w_obs1} !== {expv(m0), expv(m1)}) begin
        n_fail++;
        $display("FAIL len_edge cyc=%0d got=%h/%h want=%h/%h", c, w_obs0, w_obs1, expv(m0), expv(m1));
      end
      if (c == 0) begin
        n_checks++;
        if ({d0_dv, d0_head, d0_tail} !== 3'b111) begin
          n_fail++;
          $display("FAIL len1 got dv/head/tail=%b%b%b want=111", d0_dv, d0_head, d0_tail);
        end
      end
      if (c == 1) begin
        n_checks++;
        if ({d0_dv, d0_err} !== 2'b01) begin
          n_fail++;
          $display("FAIL len0 got dv/err=%b%b want=01", d0_dv, d0_err);
        end
      end
    end
  endtask

  task automatic test_random();
    bit r, nd, hd, tl, md;
    int len, mx;
    apply(1'b1, 1'b0, 1'b0, 1'b0, '0, 0, 0, 1'b0);
    len = 5; mx = 5; md = 0;
    for (int c = 0; c < 4000; c++) begin
      r  = ($urandom_range(0, 299) == 0);
      nd = ($urandom_range(0, 3) != 0);
      hd = ($urandom_range(0, 5) == 0);
      tl = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) begin
        len = $urandom_range(0, 12);
        mx  = $urandom_range(0, 14);
        md  = 1'($urandom_range(0, 1));
      end
      apply(r, nd, hd, tl, 16'($urandom), len, mx, md);
      n_checks++;
      if ({w_obs0, w_obs1} !== {expv(m0), expv(m1)}) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%h/%h want=%h/%h", c, w_obs0, w_obs1, expv(m0), expv(m1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_truncate();
    test_hold_pad();
    test_pacing();
    test_mid_head();
    test_reset_mid();
    test_len_edge();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
